// File: rtl/lane_driver.sv
// lane_driver: collects a two-byte, four-lane frame from a valid/ready byte stream,
// drives it onto a node's lane inputs for a programmable number of cycles, and reports the sampled node output.
module lane_driver #(
  parameter int WIDTH  = 4,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic [WIDTH-1:0]  node_out,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic [WIDTH-1:0]  out4,
  output logic              frame_active,
  output logic [WIDTH-1:0]  resp_data,
  output logic              resp_valid,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {IDLE, HALF, DRIVE} state_t;

  state_t            state, state_next;
  logic [7:0]        byte0;
  logic [HOLD_W-1:0] hold_cnt;
  logic              take0, take1, last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (take0) state_next = HALF;
      HALF:    if (take1) state_next = DRIVE;
      DRIVE:   if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode; byte_ready is itself registered and already low throughout DRIVE
  always_comb begin
    take0 = 1'b0;
    take1 = 1'b0;
    last  = 1'b0;
    unique case (state)
      IDLE:    take0 = byte_valid && byte_ready;
      HALF:    take1 = byte_valid && byte_ready;
      DRIVE:   last  = (hold_cnt == HOLD_W'(1));
      default: ;
    endcase
  end

  // Registered datapath: every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      byte_ready   <= 1'b0;
      byte0        <= '0;
      hold_cnt     <= '0;
      out1         <= '0;
      out2         <= '0;
      out3         <= '0;
      out4         <= '0;
      frame_active <= 1'b0;
      resp_data    <= '0;
      resp_valid   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      byte_ready <= (state_next != DRIVE);
      resp_valid <= last;
      if (take0) byte0 <= byte_data;
      if (take1) begin
        // All four lanes load on the same edge so the node never sees a half frame
        out1         <= byte0[WIDTH-1:0];
        out2         <= byte0[2*WIDTH-1:WIDTH];
        out3         <= byte_data[WIDTH-1:0];
        out4         <= byte_data[2*WIDTH-1:WIDTH];
        hold_cnt     <= (hold_len == '0) ? HOLD_W'(1) : hold_len;
        frame_active <= 1'b1;
      end else if (state == DRIVE) begin
        if (last) begin
          out1         <= '0;
          out2         <= '0;
          out3         <= '0;
          out4         <= '0;
          frame_active <= 1'b0;
          resp_data    <= node_out;
          frame_cnt    <= frame_cnt + 8'd1;
        end else begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/lane_driver.md
# lane_driver

Stimulus transmitter for one fabric node wrapper. Accepts a four-lane input frame as two bytes over a valid/ready byte stream. Drives the frame onto the wrapper's four 4-bit lane inputs for a programmable number of cycles, then returns the lanes to zero. Samples the node's 4-bit output on the last drive cycle and reports it as a one-cycle response, so a single byte port can exercise a node from chip IO.

## Interface

**Parameters**
- `WIDTH`, 4: lane width; the byte packs two lanes, so `2*WIDTH` must equal 8.
- `HOLD_W`, 8: width of `hold_len` and of the internal hold counter.

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `byte_data` input 8: frame byte.
  - byte0 = {lane2, lane1}.
  - byte1 = {lane4, lane3}.
  - Low nibble is the lower-numbered lane.
- `byte_valid` input 1: `byte_data` is valid.
- `byte_ready` output 1: a byte is accepted on any cycle where `byte_valid` and `byte_ready` are both high.
- `hold_len` input `HOLD_W`: number of drive cycles; sampled when byte1 is accepted; 0 is treated as 1.
- `node_out` input `WIDTH`: output of the driven node wrapper.
- `out1`..`out4` output `WIDTH` each: registered lane outputs to the wrapper's in1..in4.
- `frame_active` output 1: high during drive cycles.
- `resp_data` output `WIDTH`: `node_out` as sampled in the last drive cycle.
- `resp_valid` output 1: one-cycle pulse qualifying `resp_data`.
- `frame_cnt` output 8: number of completed frames; wraps modulo 256.

## Operation

**States**
- IDLE
  - `byte_ready`=1, lanes=0.
  - On accept: store byte0, go to HALF.
- HALF
  - `byte_ready`=1, lanes=0.
  - On accept: store byte1, latch N = max(`hold_len`,1), load the counter, go to DRIVE.
  - No timeout; HALF waits indefinitely.
- DRIVE
  - `byte_ready`=0; `byte_valid` is ignored.
  - `out1..4` show the stored frame; `frame_active`=1.
  - Stays for exactly N cycles.
  - On the last cycle: capture `node_out` into `resp_data`, go to IDLE.
- IDLE entered from DRIVE
  - `resp_valid`=1 for exactly that one cycle.
  - `frame_cnt` increments on the same edge that asserts `resp_valid`.
  - A new byte0 may be accepted in that same cycle.

**Data and arithmetic rules**
- Lanes are never partially updated.
- Outside DRIVE, all four lanes are 0.
- Byte0 data does not appear on the lanes until byte1 is accepted.
- The hold counter is `HOLD_W` bits wide.
- `hold_len` = 2^HOLD_W−1 gives the maximum hold of 255 cycles at the default width; there is no overflow.
- Changing `hold_len` during DRIVE has no effect on the current frame.
- `resp_data` holds its value until the next capture. It is not cleared when `resp_valid` falls.

**Reset**
- `rst` = 1 at any edge, in any state:
  - State goes to IDLE.
  - `out1..4`=0, `frame_active`=0, `resp_valid`=0, `resp_data`=0, `frame_cnt`=0.
  - Stored bytes are cleared.
- `byte_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Reset during DRIVE truncates the frame: no response, no count.
- Reset in HALF discards byte0.

## Timing

- Cycle T: byte0 accepted.
- Cycle T+k (k≥1): byte1 accepted.
- Cycles T+k+1 .. T+k+N: lanes driven, `frame_active`=1.
- Cycle T+k+N+1:
  - lanes=0, `resp_valid`=1.
  - `resp_data` = value of `node_out` during cycle T+k+N.
  - `byte_ready`=1.
- Minimum frame period is N+2 cycles: two accept cycles plus N drive cycles, with the first accept of the next frame overlapping the response cycle.
- All outputs are registered; none has a combinational path from any input.

## Test plan

- **Basic frame.** After reset, send 0x21 then 0x43 with `hold_len`=3.
  - `out1..4` = 1,2,3,4 for exactly 3 cycles starting the cycle after the byte1 accept.
  - Then the lanes return to 0.
  - `resp_valid` pulses once; `frame_cnt`=1.
- **Response capture.** Tie `node_out` to a counter that increments each cycle; send a frame with `hold_len`=5.
  - `resp_data` equals the counter value in the 5th drive cycle.
  - `resp_valid` is high for exactly 1 cycle.
- **Backpressure and gaps.** Hold `byte_valid` high throughout the drive period; insert 4 idle cycles between byte0 and byte1.
  - `byte_ready`=0 for the whole drive period; no byte is consumed during DRIVE.
  - The lanes stay 0 until byte1 is accepted.
- **hold_len boundaries.**
  - `hold_len`=0 gives 1 drive cycle.
  - `hold_len`=255 gives 255 drive cycles.
  - Changing `hold_len` to 1 mid-drive does not shorten the frame.
- **Back-to-back frames and wrap.** Stream 257 frames with byte0 presented in each response cycle.
  - byte0 is accepted in the response cycle.
  - `frame_cnt` reads 1 at the end.
- **Reset mid-operation.**
  - Assert `rst` on the 2nd cycle of a `hold_len`=6 frame: the next cycle shows lanes=0, `resp_valid`=0, `frame_cnt`=0.
  - Assert `rst` in HALF, then send one byte 0xFF: the lanes stay 0 (treated as byte0).
